tpu_host_arbiter: RTL and testbench



---
 rtl/tpu_io_pkg.sv | 48 ++++
 rtl/tpu_host_arbiter_rr_pick.sv | 55 +++++
 rtl/tpu_host_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_tpu_host_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_io_pkg.sv
// -----------------------------------------------------------------------------
// tpu_io_pkg
// Shared definitions for the TPU host-side I/O blocks.
//   - Control FSM state encoding used by tpu_host_arbiter.
//   - Host requester index assignments.
//   - Byte-address map of the TPU scratch memory (weights / activations /
//     results) plus a helper that classifies an address into its region.
// No ports (package).
// -----------------------------------------------------------------------------
package tpu_io_pkg;

    // Control FSM states (kept as plain constants so older tools and the
    // existing host blocks can share the same encoding).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Host requester indices.
    localparam int REQ_BTN  = 0;
    localparam int REQ_UART = 1;
    localparam int REQ_SPI  = 2;

    // Memory map (byte addresses, inclusive bounds).
    localparam logic [7:0] WGT_BASE = 8'h00;
    localparam logic [7:0] WGT_LAST = 8'h7F;
    localparam logic [7:0] ACT_BASE = 8'h80;
    localparam logic [7:0] ACT_LAST = 8'hBF;
    localparam logic [7:0] RES_BASE = 8'hC0;
    localparam logic [7:0] RES_LAST = 8'hFF;

    typedef enum logic [1:0] {
        REGION_WGT = 2'd0,
        REGION_ACT = 2'd1,
        REGION_RES = 2'd2
    } region_e;

    // Classify a byte address into its memory region.
    function automatic region_e region_of(input logic [7:0] a);
        if (a <= WGT_LAST) begin
            return REGION_WGT;
        end else if (a <= ACT_LAST) begin
            return REGION_ACT;
        end else begin
            return REGION_RES;
        end
    endfunction

endpackage

// File: rtl/tpu_host_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority encoder. Picks the lowest-index set bit of
// req at or above ptr; if none, wraps around and picks the lowest set bit
// overall.
// Ports:
//   req    in  N     request vector
//   ptr    in  PW    rotation start index
//   onehot out N     one-hot winner (0 when no request)
//   idx    out PW    winner index (0 when no request)
//   any    out 1     at least one request set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    // ge_ptr marks positions at or above the rotation pointer; masking req
    // with it yields the "upper" half of the rotation.
    logic [N-1:0] ge_ptr;
    logic [N-1:0] upper;
    logic [N-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign ge_ptr[gi] = (PW'(gi) >= ptr);
        end
    endgenerate

    assign upper = req & ge_ptr;
    assign cand  = (|upper) ? upper : req;
    assign any   = |req;

    always_comb begin
        logic found;
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && !found) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = PW'(i);
            end
        end
    end

endmodule

// File: rtl/tpu_host_arbiter.sv
// -----------------------------------------------------------------------------
// tpu_host_arbiter
// Shares the TPU byte-wide memory port and start/done handshake among N_REQ
// concurrently active host interfaces (0 = button, 1 = UART, 2 = SPI).
//   - Round-robin access grant per memory cycle; mem_* follow the winner
//     combinationally, read data is registered (latency 1).
//   - One host at a time owns a computation (start ownership uses the same
//     rotation). Writes are locked out while a computation is in flight;
//     reads continue so hosts can poll results.
//   - Watchdog aborts a run that does not signal done within TIMEOUT cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req/we/addr/wdata        per-host access request (addr/wdata packed)
//   gnt                      one-hot single-cycle access acknowledge
//   rdata/rvalid             read data (shared) and one-hot valid, 1 cycle later
//   start_req                per-host start level
//   host_done/host_err       done routed to owner / abort pulse to owner
//   mem_we/addr/wdata/rdata  memory port (rdata is combinational from memory)
//   tpu_start/busy/done      core control handshake
// -----------------------------------------------------------------------------
module tpu_host_arbiter
    import tpu_io_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       rdata,
    output logic [N_REQ-1:0]    rvalid,
    input  logic [N_REQ-1:0]    start_req,
    output logic [N_REQ-1:0]    host_done,
    output logic [N_REQ-1:0]    host_err,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic                tpu_start,
    input  logic                tpu_busy,
    input  logic                tpu_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [PW-1:0]    ptr_q,    ptr_d;
    logic [PW-1:0]    owner_q,  owner_d;
    logic [WW-1:0]    wd_q,     wd_d;
    logic             start_q,  start_d;
    logic [N_REQ-1:0] err_q,    err_d;
    logic [N_REQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q,  rdata_d;

    // ------------------------------------------------------------------
    // Unpack per-host address/data
    // ------------------------------------------------------------------
    logic [AW-1:0] addr_arr  [N_REQ];
    logic [DW-1:0] wdata_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*AW +: AW];
            assign wdata_arr[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Access arbitration
    // ------------------------------------------------------------------
    // Writes are only eligible while no computation is in flight; a write
    // granted in the same IDLE cycle that a start is accepted still lands.
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] acc_onehot;
    logic [PW-1:0]    acc_idx;
    logic             acc_any;
    logic             gnt_any;
    logic             win_we;

    assign elig = req & (~we | {N_REQ{state_q == ST_IDLE}});

    rr_pick #(.N(N_REQ), .PW(PW)) u_acc_pick (
        .req    (elig),
        .ptr    (ptr_q),
        .onehot (acc_onehot),
        .idx    (acc_idx),
        .any    (acc_any)
    );

    // No grants while reset is held so nothing reaches memory then.
    assign gnt_any   = acc_any & ~rst;
    assign win_we    = we[acc_idx];
    assign gnt       = gnt_any ? acc_onehot : '0;
    assign mem_we    = gnt_any & win_we;
    assign mem_addr  = gnt_any ? addr_arr[acc_idx]  : '0;
    assign mem_wdata = gnt_any ? wdata_arr[acc_idx] : '0;

    // ------------------------------------------------------------------
    // Start ownership (same rotation as access)
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] start_onehot;
    logic [PW-1:0]    start_idx;
    logic             start_any;

    rr_pick #(.N(N_REQ), .PW(PW)) u_start_pick (
        .req    (start_req),
        .ptr    (ptr_q),
        .onehot (start_onehot),
        .idx    (start_idx),
        .any    (start_any)
    );

    // Done is only meaningful to the host that owns the computation.
    always_comb begin
        host_done = '0;
        if (!rst && (state_q != ST_IDLE) && tpu_done) begin
            host_done[owner_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d    = ptr_q;
        if (gnt_any) begin
            ptr_d = (acc_idx == PW'(N_REQ - 1)) ? '0 : acc_idx + PW'(1);
        end

        rvalid_d = (gnt_any && !win_we) ? acc_onehot : '0;
        rdata_d  = (gnt_any && !win_we) ? mem_rdata  : rdata_q;

        state_d  = state_q;
        owner_d  = owner_q;
        wd_d     = wd_q;
        start_d  = start_q;
        err_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_any && !tpu_busy) begin
                    owner_d = start_idx;
                    start_d = 1'b1;
                    wd_d    = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wd_q != '1) begin
                    wd_d = wd_q + WW'(1);
                end
                if (tpu_done) begin
                    state_d = ST_DRAIN;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    err_d[owner_q] = 1'b1;
                    start_d        = 1'b0;
                    state_d        = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wait for the owner to release its start level so the
                // handshake closes cleanly before anyone else can start.
                if (!start_req[owner_q]) begin
                    start_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            wd_q     <= '0;
            start_q  <= 1'b0;
            err_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            wd_q     <= wd_d;
            start_q  <= start_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign host_err  = err_q;
    assign tpu_start = start_q;

endmodule

// File: tb/tb_tpu_host_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tpu_host_arbiter
// Randomized hosts, memory and core drive the arbiter; a behavioural model
// (rotation scan over host numbers, "computation active / finished" flags,
// run-cycle counter) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_tpu_host_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int NCYC = 2000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req, we, start_req;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid, host_done, host_err;
    logic [DW-1:0]   rdata;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            tpu_start, tpu_busy, tpu_done;

    logic [DW-1:0]   mem [256];
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    tpu_host_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .start_req (start_req),
        .host_done (host_done),
        .host_err  (host_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .tpu_start (tpu_start),
        .tpu_busy  (tpu_busy),
        .tpu_done  (tpu_done)
    );

    // Host stimulus state
    bit          h_pend  [N];
    bit          h_we    [N];
    bit          h_start [N];
    logic [7:0]  h_addr  [N];
    logic [7:0]  h_wdata [N];

    // Reference model state
    int          m_ptr, m_owner, m_run;
    bit          m_active, m_finished, m_start;
    logic [N-1:0] m_rvalid, m_err;
    logic [7:0]  m_rdata;

    // Per-cycle scratch
    int          win, own, hh, cyc_now;
    bit          any_start;
    logic [N-1:0] e_gnt, e_done, n_rvalid, n_err;
    logic [7:0]  e_addr, e_wdata, n_rdata;
    logic        e_we;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_now, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int h = 0; h < N; h++) begin
            h_pend[h] = 1'b0; h_we[h] = 1'b0; h_start[h] = 1'b0;
            h_addr[h] = '0;   h_wdata[h] = '0;
        end
        req = '0; we = '0; start_req = '0; addr = '0; wdata = '0;
        tpu_busy = 1'b0; tpu_done = 1'b0;
        m_ptr = 0; m_owner = 0; m_run = 0;
        m_active = 1'b0; m_finished = 1'b0; m_start = 1'b0;
        m_rvalid = '0; m_err = '0; m_rdata = '0;
        cyc_now = 0;

        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            cyc_now = cyc;

            // ---- stimulus for this cycle ----
            rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
            for (int h = 0; h < N; h++) begin
                if (!h_pend[h] && ($urandom_range(0, 99) < ((cyc < 300) ? 100 : 50))) begin
                    h_pend[h]  = 1'b1;
                    h_we[h]    = ($urandom_range(0, 9) < 4);
                    h_addr[h]  = 8'($urandom);
                    h_wdata[h] = 8'($urandom);
                end
                if ($urandom_range(0, 19) == 0) h_start[h] = !h_start[h];
            end
            tpu_busy = ($urandom_range(0, 3) == 0);
            tpu_done = ($urandom_range(0, 9) == 0);
            for (int h = 0; h < N; h++) begin
                req[h]              = h_pend[h];
                we[h]               = h_we[h];
                start_req[h]        = h_start[h];
                addr[h*AW +: AW]    = h_addr[h];
                wdata[h*DW +: DW]   = h_wdata[h];
            end
            #1;

            // ---- model: this cycle's combinational outputs ----
            win = -1;
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    hh = (m_ptr + k) % N;
                    if (win < 0 && h_pend[hh] && !(h_we[hh] && m_active)) win = hh;
                end
            end
            e_gnt   = (win >= 0) ? N'(1 << win) : '0;
            e_we    = (win >= 0) ? h_we[win]    : 1'b0;
            e_addr  = (win >= 0) ? h_addr[win]  : '0;
            e_wdata = (win >= 0) ? h_wdata[win] : '0;
            e_done  = (!rst && m_active && tpu_done) ? N'(1 << m_owner) : '0;

            check_val("gnt",       32'(gnt),       32'(e_gnt));
            check_val("mem_we",    32'(mem_we),    32'(e_we));
            check_val("mem_addr",  32'(mem_addr),  32'(e_addr));
            check_val("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            check_val("host_done", 32'(host_done), 32'(e_done));
            check_val("rvalid",    32'(rvalid),    32'(m_rvalid));
            check_val("rdata",     32'(rdata),     32'(m_rdata));
            check_val("tpu_start", 32'(tpu_start), 32'(m_start));
            check_val("host_err",  32'(host_err),  32'(m_err));

            if (win >= 0) begin
                $display("txn cycle=%0d host=%0d %s addr=%02h data=%02h", cyc, win,
                         e_we ? "wr" : "rd", e_addr, e_we ? e_wdata : mem[e_addr]);
            end

            // ---- model: advance one clock ----
            if (rst) begin
                m_ptr = 0; m_owner = 0; m_run = 0;
                m_active = 1'b0; m_finished = 1'b0; m_start = 1'b0;
                m_rvalid = '0; m_err = '0; m_rdata = '0;
            end else begin
                if (win >= 0 && !h_we[win]) begin
                    n_rvalid = N'(1 << win);
                    n_rdata  = mem[h_addr[win]];
                end else begin
                    n_rvalid = '0;
                    n_rdata  = m_rdata;
                end
                n_err = '0;
                if (!m_active) begin
                    any_start = 1'b0;
                    for (int h = 0; h < N; h++) any_start |= h_start[h];
                    if (any_start && !tpu_busy) begin
                        own = -1;
                        for (int k = 0; k < N; k++) begin
                            hh = (m_ptr + k) % N;
                            if (own < 0 && h_start[hh]) own = hh;
                        end
                        m_owner = own; m_active = 1'b1; m_finished = 1'b0;
                        m_run = 0; m_start = 1'b1;
                    end
                end else if (!m_finished) begin
                    m_run++;
                    if (tpu_done) begin
                        m_finished = 1'b1;
                    end else if (m_run == TO) begin
                        n_err = N'(1 << m_owner);
                        m_start = 1'b0;
                        m_finished = 1'b1;
                    end
                end else if (!h_start[m_owner]) begin
                    m_start = 1'b0;
                    m_active = 1'b0;
                end
                if (win >= 0) begin
                    m_ptr = (win + 1) % N;
                    if (h_we[win]) mem[h_addr[win]] = h_wdata[win];
                    h_pend[win] = 1'b0;
                end
                m_rvalid = n_rvalid;
                m_rdata  = n_rdata;
                m_err    = n_err;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
